// File: rtl/freq_display_pkg.sv
// Shared types and constants for the frequency display: conversion FSM states,
// BCD digit count and the active-low 7-segment decoder.
package freq_disp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_LOAD  = 2'd2
  } conv_state_t;

  localparam int         BCD_DIGITS  = 10;
  localparam logic [6:0] SEG_BLANK   = 7'h7F;
  // Digit codes 10..15 never come out of the BCD engine, so 4'hF marks a blank slot
  localparam logic [3:0] DIGIT_BLANK = 4'hF;

  function automatic logic [6:0] seg_pattern(input logic [3:0] digit);
    logic [6:0] seg;
    case (digit)
      4'd0:    seg = 7'b1000000;
      4'd1:    seg = 7'b1111001;
      4'd2:    seg = 7'b0100100;
      4'd3:    seg = 7'b0110000;
      4'd4:    seg = 7'b0011001;
      4'd5:    seg = 7'b0010010;
      4'd6:    seg = 7'b0000010;
      4'd7:    seg = 7'b1111000;
      4'd8:    seg = 7'b0000000;
      4'd9:    seg = 7'b0010000;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/freq_display_bin2bcd.sv
// Sequential double-dabble converter: one input bit per cycle, WIDTH cycles after start.
// done is high during the cycle that shifts in bit 0; bcd is final on the following cycle.
module bin2bcd_seq
  import freq_disp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic                    start,
  input  logic [WIDTH-1:0]        bin,
  output logic                    done,
  output logic [4*BCD_DIGITS-1:0] bcd
);

  localparam int CNT_W = $clog2(WIDTH);

  logic [WIDTH-1:0]        bin_sh;
  logic [CNT_W-1:0]        bit_cnt;
  logic                    active;
  logic [4*BCD_DIGITS-1:0] bcd_adj;

  always_comb begin
    bcd_adj = bcd;
    for (int i = 0; i < BCD_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) begin
        bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
      end
    end
  end

  assign done = active && (bit_cnt == CNT_W'(WIDTH - 1));

  always_ff @(posedge CLK) begin
    if (RESET) begin
      active  <= 1'b0;
      bit_cnt <= '0;
      bin_sh  <= '0;
      bcd     <= '0;
    end else if (start) begin
      active  <= 1'b1;
      bit_cnt <= '0;
      bin_sh  <= bin;
      bcd     <= '0;
    end else if (active) begin
      {bcd, bin_sh} <= {bcd_adj, bin_sh} << 1;
      bit_cnt       <= bit_cnt + 1'b1;
      if (done) begin
        active <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/freq_display.sv
// Shows a binary frequency on a 4-digit multiplexed 7-segment display, auto-ranging
// values above 9999 to three significant digits plus a decimal exponent.
module freq_display
  import freq_disp_pkg::*;
#(
  parameter int REFRESH_DIV = 100000,
  parameter int WIDTH       = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] freq,
  output logic [6:0]       cathode,
  output logic [3:0]       anode,
  output logic             DP,
  output logic             busy
);

  localparam int REF_W = $clog2(REFRESH_DIV);

  conv_state_t state, state_nxt;
  logic [WIDTH-1:0]             snapshot;
  logic                         conv_start;
  logic                         conv_done;
  logic [4*BCD_DIGITS-1:0]      bcd;
  logic [BCD_DIGITS-1:0][3:0]   bcd_dig;
  logic [3:0]                   msd;
  logic [3:0][3:0]              fmt_digit;
  logic [3:0]                   fmt_dp;
  logic [3:0][3:0]              disp_digit;
  logic [3:0]                   dp_mask;
  logic [REF_W-1:0]             refresh_cnt;
  logic [1:0]                   scan_idx;

  bin2bcd_seq #(.WIDTH(WIDTH)) u_bin2bcd (
    .CLK   (CLK),
    .RESET (RESET),
    .start (conv_start),
    .bin   (freq),
    .done  (conv_done),
    .bcd   (bcd)
  );

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state    <= ST_IDLE;
      snapshot <= '0;
    end else begin
      state <= state_nxt;
      if (conv_start) begin
        snapshot <= freq;
      end
    end
  end

  // A changed input is only noticed in IDLE, so a change during conversion is picked up afterwards
  always_comb begin
    state_nxt  = state;
    conv_start = 1'b0;
    case (state)
      ST_IDLE: begin
        if (freq != snapshot) begin
          conv_start = 1'b1;
          state_nxt  = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (conv_done) begin
          state_nxt = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  assign busy    = (state != ST_IDLE);
  assign bcd_dig = bcd;

  // Large values: three truncated significant digits, exponent in the rightmost slot
  always_comb begin
    msd       = '0;
    fmt_digit = '0;
    fmt_dp    = '0;
    for (int i = 1; i < BCD_DIGITS; i++) begin
      if (bcd_dig[i] != 4'd0) begin
        msd = 4'(i);
      end
    end
    if (msd < 4'd4) begin
      for (int j = 0; j < 4; j++) begin
        fmt_digit[j] = (j == 0 || 4'(j) <= msd) ? bcd_dig[j] : DIGIT_BLANK;
      end
    end else begin
      fmt_digit[3] = bcd_dig[msd];
      fmt_digit[2] = bcd_dig[msd - 4'd1];
      fmt_digit[1] = bcd_dig[msd - 4'd2];
      fmt_digit[0] = msd - 4'd2;
      fmt_dp       = 4'b0010;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      disp_digit <= {DIGIT_BLANK, DIGIT_BLANK, DIGIT_BLANK, 4'd0};
      dp_mask    <= '0;
    end else if (state == ST_LOAD) begin
      disp_digit <= fmt_digit;
      dp_mask    <= fmt_dp;
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      refresh_cnt <= '0;
      scan_idx    <= '0;
    end else if (refresh_cnt == REF_W'(REFRESH_DIV - 1)) begin
      refresh_cnt <= '0;
      scan_idx    <= scan_idx + 2'd1;
    end else begin
      refresh_cnt <= refresh_cnt + 1'b1;
    end
  end

  // Anode, segments and DP are registered together so a slot never mixes two digits
  always_ff @(posedge CLK) begin
    if (RESET) begin
      anode   <= 4'b1111;
      cathode <= SEG_BLANK;
      DP      <= 1'b1;
    end else begin
      anode   <= ~(4'b0001 << scan_idx);
      cathode <= seg_pattern(disp_digit[scan_idx]);
      DP      <= ~dp_mask[scan_idx];
    end
  end

endmodule

// File: tb/tb_freq_display.sv
// Self-checking bench for freq_display: directed corner values plus random frequencies,
// compared against an arithmetic model of the auto-ranged 4-digit display.
module tb_freq_display;

  localparam int REFRESH_DIV = 4;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] freq;
  logic [6:0]  cathode;
  logic [3:0]  anode;
  logic        DP;
  logic        busy;

  int n_cmp = 0;
  int n_bad = 0;

  int   exp_digit [4];
  logic exp_dp    [4];

  freq_display #(.REFRESH_DIV(REFRESH_DIV), .WIDTH(32)) dut (
    .CLK     (CLK),
    .RESET   (RESET),
    .freq    (freq),
    .cathode (cathode),
    .anode   (anode),
    .DP      (DP),
    .busy    (busy)
  );

  always #5 CLK = ~CLK;

  function automatic logic [6:0] seg_of(input int d);
    case (d)
      0:       return 7'h40;
      1:       return 7'h79;
      2:       return 7'h24;
      3:       return 7'h30;
      4:       return 7'h19;
      5:       return 7'h12;
      6:       return 7'h02;
      7:       return 7'h78;
      8:       return 7'h00;
      9:       return 7'h10;
      default: return 7'h7F;
    endcase
  endfunction

  // Blank digits are modelled as -1; exp_dp is 1 where the decimal point is lit
  task automatic model(input logic [31:0] v);
    longint val;
    longint p;
    longint pw;
    longint scale;
    longint top;
    int     n;
    val = v;
    for (int i = 0; i < 4; i++) exp_dp[i] = 1'b0;
    if (val <= 9999) begin
      pw = 1;
      for (int i = 0; i < 4; i++) begin
        exp_digit[i] = (i == 0 || val >= pw) ? int'((val / pw) % 10) : -1;
        pw = pw * 10;
      end
    end else begin
      n = 1;
      p = 10;
      while (val >= p) begin
        n++;
        p = p * 10;
      end
      scale = 1;
      for (int j = 0; j < n - 3; j++) scale = scale * 10;
      top          = val / scale;
      exp_digit[3] = int'(top / 100);
      exp_digit[2] = int'((top / 10) % 10);
      exp_digit[1] = int'(top % 10);
      exp_digit[0] = n - 3;
      exp_dp[1]    = 1'b1;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic applyStimulus(input logic [31:0] v);
    @(negedge CLK);
    freq = v;
  endtask

  task automatic waitConversion(input string tag, output int cyc);
    int guard;
    guard = 0;
    cyc   = 0;
    while (guard < 120) begin
      @(negedge CLK);
      guard++;
      if (busy === 1'b1) cyc++;
      else if (cyc > 0) break;
    end
    if (guard >= 120) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
  endtask

  task automatic checkDisplay(input string tag);
    logic [3:0] seen;
    logic [3:0] a_exp;
    int         idx;
    seen = '0;
    repeat (2) @(negedge CLK);
    repeat (4 * REFRESH_DIV) begin
      @(negedge CLK);
      idx = -1;
      for (int i = 0; i < 4; i++) begin
        a_exp = ~(4'b0001 << i);
        if (anode === a_exp) idx = i;
      end
      checkOutput({tag, "_anode_onehot"}, {31'd0, idx >= 0}, 32'd1);
      if (idx >= 0) begin
        seen[idx] = 1'b1;
        checkOutput($sformatf("%s_cathode_d%0d", tag, idx), {25'd0, cathode},
                    {25'd0, seg_of(exp_digit[idx])});
        checkOutput($sformatf("%s_dp_d%0d", tag, idx), {31'd0, DP}, {31'd0, ~exp_dp[idx]});
      end
    end
    checkOutput({tag, "_all_slots"}, {28'd0, seen}, 32'h0000000F);
  endtask

  task automatic convertAndCheck(input string tag, input logic [31:0] v);
    int cyc;
    applyStimulus(v);
    waitConversion(tag, cyc);
    checkOutput({tag, "_busy_cycles"}, cyc, 32'd33);
    model(v);
    checkDisplay(tag);
  endtask

  initial begin
    logic [31:0] prev;
    logic [31:0] v;
    logic [3:0]  a_exp;
    int          cyc;
    int          busy_seen;

    $display("[TB] start");
    RESET = 1'b1;
    freq  = 32'd0;

    repeat (3) begin
      @(negedge CLK);
      checkOutput("rst_anode", {28'd0, anode}, 32'hF);
      checkOutput("rst_cathode", {25'd0, cathode}, 32'h7F);
      checkOutput("rst_dp", {31'd0, DP}, 32'd1);
      checkOutput("rst_busy", {31'd0, busy}, 32'd0);
    end
    RESET = 1'b0;

    for (int c = 0; c < 4 * 4 * REFRESH_DIV / 4 * 1; c++) begin
      @(negedge CLK);
      a_exp = ~(4'b0001 << ((c / REFRESH_DIV) % 4));
      checkOutput("scan_anode", {28'd0, anode}, {28'd0, a_exp});
      checkOutput("scan_cathode", {25'd0, cathode},
                  ((c / REFRESH_DIV) % 4 == 0) ? 32'h40 : 32'h7F);
      checkOutput("scan_dp", {31'd0, DP}, 32'd1);
      checkOutput("scan_busy", {31'd0, busy}, 32'd0);
    end

    convertAndCheck("f1234", 32'd1234);
    convertAndCheck("f12345678", 32'd12345678);
    convertAndCheck("f10000", 32'd10000);
    convertAndCheck("f9999", 32'd9999);
    convertAndCheck("fmax", 32'hFFFFFFFF);
    convertAndCheck("f0", 32'd0);
    convertAndCheck("f7", 32'd7);

    prev = 32'd7;
    for (int r = 0; r < 10; r++) begin
      v = $urandom >> $urandom_range(0, 31);
      if (v == prev) v = v ^ 32'd1;
      convertAndCheck($sformatf("rand%0d", r), v);
      prev = v;
    end

    // Input change part-way through a conversion
    applyStimulus(32'd500);
    @(negedge CLK);
    checkOutput("midchg_busy_rise", {31'd0, busy}, 32'd1);
    repeat (9) @(negedge CLK);
    freq = 32'd700;
    waitConversion("midchg_first", cyc);
    model(32'd500);
    checkDisplay("midchg_500");
    waitConversion("midchg_second", cyc);
    model(32'd700);
    checkDisplay("midchg_700");
    busy_seen = 0;
    repeat (40) begin
      @(negedge CLK);
      if (busy === 1'b1) busy_seen++;
    end
    checkOutput("midchg_no_extra", busy_seen, 32'd0);

    // Reset pulse during SHIFT
    applyStimulus(32'd4321);
    @(negedge CLK);
    checkOutput("rstmid_busy_rise", {31'd0, busy}, 32'd1);
    repeat (5) @(negedge CLK);
    RESET = 1'b1;
    freq  = 32'd0;
    @(negedge CLK);
    checkOutput("rstmid_busy", {31'd0, busy}, 32'd0);
    checkOutput("rstmid_anode", {28'd0, anode}, 32'hF);
    checkOutput("rstmid_cathode", {25'd0, cathode}, 32'h7F);
    RESET = 1'b0;
    @(negedge CLK);
    checkOutput("rstmid_busy_after", {31'd0, busy}, 32'd0);
    model(32'd0);
    checkDisplay("rstmid_zero");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
